// File: rtl/biquinary_seq_ctrl.sv
// biquinary_seq_ctrl: command-driven synchronous BCD decade chain with target match, wrap and biquinary view
module biquinary_seq_ctrl #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [4*DIGITS-1:0]   cmd_data,
   input  logic [4*DIGITS-1:0]   target,
   input  logic                  tick,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic [4*DIGITS-1:0]   count_bq,
   output logic                  running,
   output logic                  done,
   output logic                  match,
   output logic                  wrap
);
   localparam int W = 4*DIGITS;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'b00, OP_LOAD = 2'b01, OP_START = 2'b10;
   logic [1:0]   state_q, state_d;
   logic [W-1:0] count_q, count_d, tgt_q, tgt_d, inc;
   logic         ready_q, ready_d, match_q, match_d, wrap_q, wrap_d, all9, accept;
   function automatic logic [W-1:0] bcd_fix(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
      return r;
   endfunction
   // decimal increment; all9 ends high only when every digit carried
   always_comb begin
      all9 = 1'b1;
      inc  = count_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (all9) inc[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
         all9 = all9 & (count_q[4*i +: 4] == 4'd9);
      end
   end
   assign accept = cmd_valid & ready_q;
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tgt_d   = tgt_q;
      ready_d = ~accept;
      match_d = 1'b0;
      wrap_d  = 1'b0;
      if (accept) begin
         case (cmd_op)
            OP_CLEAR: begin count_d = '0; state_d = IDLE; end
            OP_LOAD:  begin count_d = bcd_fix(cmd_data); state_d = IDLE; end
            OP_START: begin tgt_d = bcd_fix(target); state_d = RUN; end
            default:  state_d = (state_q == RUN) ? IDLE : state_q;
         endcase
      end else if (state_q == RUN && tick) begin
         count_d = inc;
         wrap_d  = all9;
         match_d = (inc == tgt_q);
         state_d = (inc == tgt_q) ? DONE : RUN;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         count_q <= '0;
         tgt_q   <= '0;
         ready_q <= 1'b1;
         match_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tgt_q   <= tgt_d;
         ready_q <= ready_d;
         match_q <= match_d;
         wrap_q  <= wrap_d;
      end
   end
   assign cmd_ready = ready_q;
   assign count_bcd = count_q;
   assign running   = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign match     = match_q;
   assign wrap      = wrap_q;
   // for d>=5 the low three bits minus 5 (mod 8) give d mod 5
   for (genvar g = 0; g < DIGITS; g++) begin : g_bq
      logic [3:0] d;
      logic       bi;
      assign d  = count_q[4*g +: 4];
      assign bi = (d >= 4'd5);
      assign count_bq[4*g +: 4] = {d[2:0] - (bi ? 3'd5 : 3'd0), bi};
   end
endmodule
